// File: rtl/branch_flag_resolver.sv
// -----------------------------------------------------------------------------
// branch_flag_resolver
//
// One-entry registered stage between the execute-stage flagger and PC-update
// logic. Takes the Z/N/V/C flags of (rs1 - rs2), resolves the RISC-V
// conditional branch selected by funct3, and holds taken / next_pc / illegal /
// misaligned until downstream accepts. Also keeps saturating taken and
// not-taken counters of accepted results.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   in_valid / in_ready  upstream handshake (in_ready = EMPTY || out_ready)
//   funct3, flags        branch selector and flagger output {C,V,N,Z}
//   pc, imm              branch address and sign-extended B-type offset
//   flush                drop held entry and any same-cycle capture
//   out_valid/out_ready  downstream handshake
//   taken, next_pc       resolved direction and target (pc+imm or pc+4)
//   illegal, misaligned  funct3 in {010,011}; taken target not word aligned
//   cnt_clear            synchronous clear of both counters
//   taken_cnt, not_taken_cnt  saturating counts of accepted results
// -----------------------------------------------------------------------------
module branch_flag_resolver #(
  parameter int WORDSIZE = 64,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          funct3,
  input  logic [3:0]          flags,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] imm,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                taken,
  output logic [WORDSIZE-1:0] next_pc,
  output logic                illegal,
  output logic                misaligned,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    taken_cnt,
  output logic [CNT_W-1:0]    not_taken_cnt
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic w_z, w_n, w_v, w_c;
  logic w_taken, w_illegal, w_mis;
  logic [WORDSIZE-1:0] w_next_pc;
  logic w_capture, w_consume;

  logic                r_taken, r_illegal, r_mis;
  logic [WORDSIZE-1:0] r_next_pc;
  logic [CNT_W-1:0]    r_taken_cnt, r_not_taken_cnt;

  // ---------------------------------------------------------------------------
  // Branch resolution (combinational from the incoming request)
  // ---------------------------------------------------------------------------
  assign {w_c, w_v, w_n, w_z} = flags;

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (funct3)
      3'b000:  w_taken = w_z;              // BEQ
      3'b001:  w_taken = ~w_z;             // BNE
      3'b100:  w_taken = w_n ^ w_v;        // BLT
      3'b101:  w_taken = ~(w_n ^ w_v);     // BGE
      3'b110:  w_taken = ~w_c;             // BLTU: carry clear means a < b
      3'b111:  w_taken = w_c;              // BGEU
      default: w_illegal = 1'b1;           // 010/011 are not branches
    endcase
  end

  // Both sums wrap at WORDSIZE bits; the carry is intentionally dropped.
  assign w_next_pc = w_taken ? (pc + imm) : (pc + WORDSIZE'(4));
  assign w_mis     = w_taken && (w_next_pc[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // Handshake qualifiers; flush overrides both directions
  // ---------------------------------------------------------------------------
  assign w_capture = in_valid  && in_ready  && !flush;
  assign w_consume = out_valid && out_ready && !flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_capture) w_state_nxt = ST_FULL;
        ST_FULL:  begin
          // Back-to-back consume + capture keeps the stage full.
          if (w_consume && !w_capture) w_state_nxt = ST_EMPTY;
        end
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // FSM: outputs. in_ready depends only on state and out_ready, so there is
  // no combinational path from in_valid to out_valid.
  always_comb begin
    out_valid = (r_state == ST_FULL);
    in_ready  = (r_state == ST_EMPTY) || out_ready;
  end

  // ---------------------------------------------------------------------------
  // Result holding register: loads only on an accepted, unflushed capture, so
  // values stay put while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
      r_mis     <= 1'b0;
      r_next_pc <= '0;
    end else if (w_capture) begin
      r_taken   <= w_taken;
      r_illegal <= w_illegal;
      r_mis     <= w_mis;
      r_next_pc <= w_next_pc;
    end
  end

  assign taken      = r_taken;
  assign illegal    = r_illegal;
  assign misaligned = r_mis;
  assign next_pc    = r_next_pc;

  // ---------------------------------------------------------------------------
  // Performance counters: bump on an output handshake, saturate at all-ones.
  // Illegal results are never taken, so they land in the not-taken count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else if (cnt_clear) begin
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else if (w_consume) begin
      if (r_taken) begin
        if (!(&r_taken_cnt)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end else begin
        if (!(&r_not_taken_cnt)) r_not_taken_cnt <= r_not_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;

endmodule

// File: tb/tb_branch_flag_resolver.sv
module tb_branch_flag_resolver;
  localparam int WS   = 64;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    funct3 = '0;
  logic [3:0]    flags = '0;
  logic [WS-1:0] pc = '0, imm = '0, next_pc;
  logic          flush = 1'b0, out_valid, out_ready = 1'b0;
  logic          taken, illegal, misaligned, cnt_clear = 1'b0;
  logic [CW-1:0] taken_cnt, not_taken_cnt;

  // Operands behind the current flags; the model resolves from these.
  logic [WS-1:0] cur_a = '0, cur_b = '0;

  typedef struct packed {
    logic          t;
    logic [WS-1:0] npc;
    logic          ill;
    logic          mis;
  } exp_t;

  exp_t exp_q[$];
  int   mt = 0, mn = 0;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  branch_flag_resolver #(.WORDSIZE(WS), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .flags(flags), .pc(pc), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .next_pc(next_pc), .illegal(illegal), .misaligned(misaligned),
    .cnt_clear(cnt_clear), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  // Flagger for a - b: {C, V, N, Z}
  function automatic logic [3:0] flagger(input logic [WS-1:0] a, input logic [WS-1:0] b);
    logic [WS-1:0] r;
    r = a - b;
    return {a >= b, (a[WS-1] != b[WS-1]) && (r[WS-1] != a[WS-1]), r[WS-1], r == '0};
  endfunction

  // Branch outcome straight from the operands, not from the flags.
  function automatic exp_t predict(input logic [2:0] f3, input logic [WS-1:0] a,
                                   input logic [WS-1:0] b, input logic [WS-1:0] p,
                                   input logic [WS-1:0] i);
    exp_t e;
    e.t = 1'b0;
    e.ill = 1'b0;
    case (f3)
      3'd0:    e.t = (a == b);
      3'd1:    e.t = (a != b);
      3'd4:    e.t = ($signed(a) <  $signed(b));
      3'd5:    e.t = ($signed(a) >= $signed(b));
      3'd6:    e.t = (a <  b);
      3'd7:    e.t = (a >= b);
      default: e.ill = 1'b1;
    endcase
    e.npc = e.t ? p + i : p + 64'd4;
    e.mis = e.t && (e.npc[1:0] != 2'b00);
    return e;
  endfunction

  task automatic set_br(input logic [2:0] f3, input logic [WS-1:0] a, input logic [WS-1:0] b,
                        input logic [WS-1:0] p, input logic [WS-1:0] i);
    in_valid = 1'b1;
    funct3 = f3;
    cur_a = a;
    cur_b = b;
    flags = flagger(a, b);
    pc = p;
    imm = i;
  endtask

  // Advance one clock and update the transaction-level model.
  task automatic cycle();
    bit rdy, cap, cons;
    rdy  = (exp_q.size() == 0) || out_ready;
    cap  = in_valid && rdy && !flush;
    cons = (exp_q.size() != 0) && out_ready && !flush;
    if (cnt_clear) begin
      mt = 0; mn = 0;
    end else if (cons) begin
      if (exp_q[0].t) begin if (mt < MAXC) mt++; end
      else begin if (mn < MAXC) mn++; end
    end
    if (flush) exp_q.delete();
    else begin
      if (cons) void'(exp_q.pop_front());
      if (cap) exp_q.push_back(predict(funct3, cur_a, cur_b, pc, imm));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0; cnt_clear = 1'b1; out_ready = 1'b1;
    cycle();
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    total++;
    if ({taken, illegal, misaligned} !== 3'b000 || next_pc !== '0) begin
      bad++; $display("FAIL reset_data: t/i/m=%b%b%b next_pc=%h want 000/0", taken, illegal, misaligned, next_pc);
    end
    total++;
    if (taken_cnt !== '0 || not_taken_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt: %0d/%0d want 0/0", taken_cnt, not_taken_cnt);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete(); mt = 0; mn = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || taken_cnt !== '0 ||
          not_taken_cnt !== '0 || next_pc !== '0) begin
        bad++; $display("FAIL idle%0d: ov=%b ir=%b cnt=%0d/%0d npc=%h want 0/1/0/0/0",
                        k, out_valid, in_ready, taken_cnt, not_taken_cnt, next_pc);
      end
    end
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    set_br(3'b000, 64'd2, 64'd2, 64'h100, 64'h20);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL beq_in_ready: %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 64'h120) begin
      bad++; $display("FAIL beq_result: ov=%b t=%b npc=%h want 1/1/120", out_valid, taken, next_pc);
    end
    cycle();
    total++;
    if (out_valid !== 1'b0 || taken_cnt !== 2'd1 || not_taken_cnt !== 2'd0) begin
      bad++; $display("FAIL beq_count: ov=%b cnt=%0d/%0d want 0/1/0", out_valid, taken_cnt, not_taken_cnt);
    end
  endtask

  task automatic test_blt_bgeu();
    out_ready = 1'b1;
    set_br(3'b100, 64'h8000_0000_0000_0000, 64'd1, 64'h1000, 64'h40);
    cycle();
    total++;
    if (out_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 64'h1040) begin
      bad++; $display("FAIL blt: ov=%b t=%b npc=%h want 1/1/1040", out_valid, taken, next_pc);
    end
    set_br(3'b111, 64'd5, {WS{1'b1}}, 64'h2000, 64'h80);
    cycle();
    total++;
    if (out_valid !== 1'b1 || taken !== 1'b0 || next_pc !== 64'h2004) begin
      bad++; $display("FAIL bgeu: ov=%b t=%b npc=%h want 1/0/2004", out_valid, taken, next_pc);
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (taken_cnt !== CW'(mt) || not_taken_cnt !== CW'(mn)) begin
      bad++; $display("FAIL blt_bgeu_cnt: %0d/%0d want %0d/%0d", taken_cnt, not_taken_cnt, mt, mn);
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    out_ready = 1'b0;
    set_br(3'b001, 64'd3, 64'd4, 64'h300, 64'h10);
    cycle();
    set_br(3'b110, 64'd7, 64'd9, 64'h400, 64'h8);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: %b want 0", k, in_ready); end
      cycle();
      total++;
      if (out_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 64'h310) begin
        bad++; $display("FAIL bp_hold%0d: ov=%b t=%b npc=%h want 1/1/310", k, out_valid, taken, next_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: in_ready=%b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || next_pc !== 64'h408) begin
      bad++; $display("FAIL bp_second: ov=%b npc=%h want 1/408", out_valid, next_pc);
    end
    cycle();
    total++;
    if (out_valid !== 1'b0 || taken_cnt !== 2'd2 || not_taken_cnt !== 2'd0) begin
      bad++; $display("FAIL bp_count: ov=%b cnt=%0d/%0d want 0/2/0", out_valid, taken_cnt, not_taken_cnt);
    end
  endtask

  task automatic test_illegal_misaligned_wrap();
    do_clear();
    set_br(3'b010, 64'd0, 64'd0, 64'h500, 64'h40);
    cycle();
    total++;
    if (illegal !== 1'b1 || taken !== 1'b0 || next_pc !== 64'h504 || misaligned !== 1'b0) begin
      bad++; $display("FAIL illegal: i=%b t=%b npc=%h m=%b want 1/0/504/0", illegal, taken, next_pc, misaligned);
    end
    set_br(3'b001, 64'd1, 64'd2, 64'h200, 64'h2);
    cycle();
    total++;
    if (misaligned !== 1'b1 || taken !== 1'b1 || next_pc !== 64'h202 || illegal !== 1'b0) begin
      bad++; $display("FAIL misaligned: m=%b t=%b npc=%h i=%b want 1/1/202/0", misaligned, taken, next_pc, illegal);
    end
    set_br(3'b000, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10);
    cycle();
    total++;
    if (taken !== 1'b0 || next_pc !== 64'h0 || misaligned !== 1'b0) begin
      bad++; $display("FAIL wrap: t=%b npc=%h m=%b want 0/0/0", taken, next_pc, misaligned);
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (taken_cnt !== 2'd1 || not_taken_cnt !== 2'd2) begin
      bad++; $display("FAIL imw_count: %0d/%0d want 1/2", taken_cnt, not_taken_cnt);
    end
  endtask

  task automatic test_flush();
    do_clear();
    set_br(3'b000, 64'd9, 64'd9, 64'h600, 64'h4);
    cycle();
    set_br(3'b000, 64'd9, 64'd9, 64'h700, 64'h4);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || taken_cnt !== 2'd0 || not_taken_cnt !== 2'd0) begin
      bad++; $display("FAIL flush: ov=%b cnt=%0d/%0d want 0/0/0", out_valid, taken_cnt, not_taken_cnt);
    end
    cycle();
    total++;
    if (out_valid !== 1'b0 || taken_cnt !== 2'd0) begin
      bad++; $display("FAIL flush_after: ov=%b tcnt=%0d want 0/0", out_valid, taken_cnt);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int k = 0; k < 5; k++) begin
      set_br(3'b000, 64'd6, 64'd6, 64'h800, 64'h10);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (taken_cnt !== 2'd3 || not_taken_cnt !== 2'd0) begin
      bad++; $display("FAIL saturate: %0d/%0d want 3/0", taken_cnt, not_taken_cnt);
    end
  endtask

  task automatic test_clear();
    do_clear();
    set_br(3'b000, 64'd1, 64'd1, 64'h900, 64'h8);
    cycle();
    set_br(3'b101, 64'd3, 64'd4, 64'h940, 64'h8);
    cycle();
    in_valid = 1'b0;
    total++;
    if (taken_cnt !== 2'd1 || out_valid !== 1'b1 || taken !== 1'b0) begin
      bad++; $display("FAIL pre_clear: tcnt=%0d ov=%b t=%b want 1/1/0", taken_cnt, out_valid, taken);
    end
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    total++;
    if (taken_cnt !== 2'd0 || not_taken_cnt !== 2'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL clear_hs: cnt=%0d/%0d ov=%b want 0/0/0", taken_cnt, not_taken_cnt, out_valid);
    end
  endtask

  task automatic test_random();
    logic [WS-1:0] a, b, p, i;
    logic [12:0]   r13;
    logic [2:0]    f3;
    bit            exp_rdy;
    do_clear();
    for (int k = 0; k < 400; k++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 64'($urandom_range(0, 3)) - 64'd1;
        2:       b = {$urandom, $urandom};
        default: begin a = 64'($urandom_range(0, 7)); b = 64'($urandom_range(0, 7)); end
      endcase
      p = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))
                                      : {$urandom, $urandom};
      r13 = 13'($urandom) & 13'h1FFE;
      i = {{(WS-13){r13[12]}}, r13};
      f3 = 3'($urandom_range(0, 7));
      set_br(f3, a, b, p, i);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cnt_clear = ($urandom_range(0, 31) == 0);
      exp_rdy   = (exp_q.size() == 0) || out_ready;
      #1;
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rnd_in_ready@%0d: %b want %b", k, in_ready, exp_rdy);
      end
      cycle();
      total++;
      if (out_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid@%0d: %b want %b", k, out_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0) begin
        total++;
        if ({taken, next_pc, illegal, misaligned} !== exp_q[0]) begin
          bad++; $display("FAIL rnd_data@%0d: t=%b npc=%h i=%b m=%b want t=%b npc=%h i=%b m=%b", k,
                          taken, next_pc, illegal, misaligned,
                          exp_q[0].t, exp_q[0].npc, exp_q[0].ill, exp_q[0].mis);
        end
      end
      total++;
      if (taken_cnt !== CW'(mt) || not_taken_cnt !== CW'(mn)) begin
        bad++; $display("FAIL rnd_cnt@%0d: %0d/%0d want %0d/%0d", k, taken_cnt, not_taken_cnt, mt, mn);
      end
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clear = 1'b0; out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset_midop();
    do_clear();
    set_br(3'b000, 64'd4, 64'd4, 64'hA00, 64'h8);
    cycle();
    set_br(3'b000, 64'd4, 64'd4, 64'hB00, 64'h8);
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (taken_cnt !== 2'd1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: tcnt=%0d ov=%b want 1/1", taken_cnt, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || taken_cnt !== '0 ||
        not_taken_cnt !== '0 || next_pc !== '0 || taken !== 1'b0) begin
      bad++; $display("FAIL midrst: ov=%b ir=%b cnt=%0d/%0d npc=%h t=%b want 0/1/0/0/0/0",
                      out_valid, in_ready, taken_cnt, not_taken_cnt, next_pc, taken);
    end
    exp_q.delete(); mt = 0; mn = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    total++;
    if (out_valid !== 1'b0 || taken_cnt !== '0) begin
      bad++; $display("FAIL midrst_after: ov=%b tcnt=%0d want 0/0", out_valid, taken_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bgeu();
    test_backpressure();
    test_illegal_misaligned_wrap();
    test_flush();
    test_saturation();
    test_clear();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
